// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for a 5-stage RISC-V pipeline: operand forwarding,
// load-use/mispredict handling, multi-cycle EX sequencing with watchdog, stall counter.
module hazard_ctrl_unit #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_E,
    input  logic [4:0]       rd_M,
    input  logic [4:0]       rd_W,
    input  logic [1:0]       write_back_E,
    input  logic             write_enable_RF_M,
    input  logic             write_enable_RF_W,
    input  logic             mispredict_E,
    input  logic             mc_req_E,
    input  logic             mc_done,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       forwardA_E,
    output logic [1:0]       forwardB_E,
    output logic             mc_start,
    output logic             mc_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic STATE_IDLE    = 1'b0;
    localparam logic STATE_MC_BUSY = 1'b1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [1:0] WB_SEL_LOAD = 2'b01;

    // Watchdog counts 0 .. MC_TIMEOUT-1 while busy; the last value triggers the abort.
    localparam int              TMO_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);

    logic             state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mc_start_q, mc_start_d;
    logic             mc_error_q, mc_error_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mc_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       we_m,
        input logic [4:0] dst_m,
        input logic       we_w,
        input logic [4:0] dst_w
    );
        if (we_m && (dst_m != 5'd0) && (dst_m == src)) begin
            return FWD_MEM;
        end else if (we_w && (dst_w != 5'd0) && (dst_w == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign forwardA_E = fwd_sel(rs1_E, write_enable_RF_M, rd_M, write_enable_RF_W, rd_W);
    assign forwardB_E = fwd_sel(rs2_E, write_enable_RF_M, rd_M, write_enable_RF_W, rd_W);

    assign load_use = (write_back_E == WB_SEL_LOAD) && (rd_E != 5'd0)
                   && ((rd_E == rs1_D) || (rd_E == rs2_D));

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        mc_start_d = 1'b0;
        mc_error_d = mc_error_q;
        mc_stall   = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (mc_req_E && !mispredict_E) begin
                    mc_stall   = 1'b1;
                    state_d    = STATE_MC_BUSY;
                    mc_start_d = 1'b1;
                    tmo_d      = '0;
                end
            end
            STATE_MC_BUSY: begin
                if (mc_done) begin
                    state_d = STATE_IDLE;
                end else begin
                    // Stalls stay up in the abort cycle and drop once back in IDLE.
                    mc_stall = 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        mc_error_d = 1'b1;
                        state_d    = STATE_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // A mispredict must let the redirected fetch through, so it beats any front-end stall.
    assign StallF = (mc_stall || load_use) && !mispredict_E;
    assign StallD = (mc_stall || load_use) && !mispredict_E;
    assign StallE = mc_stall;
    assign FlushD = mispredict_E;
    assign FlushE = !mc_stall && (mispredict_E || load_use);
    assign FlushM = mc_stall;

    assign stall_cnt_d = (StallF && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_IDLE;
            tmo_q       <= '0;
            mc_start_q  <= 1'b0;
            mc_error_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            mc_start_q  <= mc_start_d;
            mc_error_q  <= mc_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mc_start     = mc_start_q;
    assign mc_error     = mc_error_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit; a second instance with
// MC_TIMEOUT=4 and CNT_W=4 covers the watchdog and counter saturation.
`timescale 1ns/1ps
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic [1:0]  write_back_E;
    logic        write_enable_RF_M, write_enable_RF_W;
    logic        mispredict_E, mc_req_E, mc_done;

    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]  forwardA_E, forwardB_E;
    logic        mc_start, mc_error;
    logic [31:0] stall_cycles;

    logic        s_StallF, s_StallD, s_StallE, s_FlushD, s_FlushE, s_FlushM;
    logic [1:0]  s_forwardA_E, s_forwardB_E;
    logic        s_mc_start, s_mc_error;
    logic [3:0]  s_stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .write_back_E(write_back_E),
        .write_enable_RF_M(write_enable_RF_M), .write_enable_RF_W(write_enable_RF_W),
        .mispredict_E(mispredict_E), .mc_req_E(mc_req_E), .mc_done(mc_done),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .mc_start(mc_start), .mc_error(mc_error), .stall_cycles(stall_cycles)
    );

    hazard_ctrl_unit #(.MC_TIMEOUT(4), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .write_back_E(write_back_E),
        .write_enable_RF_M(write_enable_RF_M), .write_enable_RF_W(write_enable_RF_W),
        .mispredict_E(mispredict_E), .mc_req_E(mc_req_E), .mc_done(mc_done),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushM(s_FlushM),
        .forwardA_E(s_forwardA_E), .forwardB_E(s_forwardB_E),
        .mc_start(s_mc_start), .mc_error(s_mc_error), .stall_cycles(s_stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_D = 5'd0; rs2_D = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
        rd_E = 5'd0; rd_M = 5'd0; rd_W = 5'd0; write_back_E = 2'b00;
        write_enable_RF_M = 1'b0; write_enable_RF_W = 1'b0;
        mispredict_E = 1'b0; mc_req_E = 1'b0; mc_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] flags;
        do_reset();
        flags = {StallF, StallD, StallE, FlushD, FlushE, FlushM, forwardA_E, forwardB_E};
        n_cmp++;
        if (flags !== 10'd0) begin
            n_err++; $display("FAIL reset_comb: got %b expected 0", flags);
        end
        n_cmp++;
        if ({mc_start, mc_error} !== 2'b00 || stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL reset_regs: start=%b err=%b cnt=%0d expected 0/0/0",
                              mc_start, mc_error, stall_cycles);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rd_M = 5'd5; rd_W = 5'd5; write_enable_RF_M = 1'b1; write_enable_RF_W = 1'b1;
        rs1_E = 5'd5; rs2_E = 5'd0;
        #1;
        n_cmp++;
        if (forwardA_E !== 2'b10 || forwardB_E !== 2'b00) begin
            n_err++; $display("FAIL fwd_mem_prio: A=%b B=%b expected 10 00", forwardA_E, forwardB_E);
        end
        write_enable_RF_M = 1'b0;
        #1;
        n_cmp++;
        if (forwardA_E !== 2'b01) begin
            n_err++; $display("FAIL fwd_wb: A=%b expected 01", forwardA_E);
        end
        write_enable_RF_M = 1'b1; rd_M = 5'd9; rd_W = 5'd3; rs1_E = 5'd3; rs2_E = 5'd9;
        #1;
        n_cmp++;
        if (forwardA_E !== 2'b01 || forwardB_E !== 2'b10) begin
            n_err++; $display("FAIL fwd_split: A=%b B=%b expected 01 10", forwardA_E, forwardB_E);
        end
        rd_M = 5'd0; rd_W = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
        #1;
        n_cmp++;
        if (forwardA_E !== 2'b00 || forwardB_E !== 2'b00) begin
            n_err++; $display("FAIL fwd_x0: A=%b B=%b expected 00 00", forwardA_E, forwardB_E);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        write_back_E = 2'b01; rd_E = 5'd7; rs2_D = 5'd7;
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100) begin
            n_err++; $display("FAIL load_use: F/D/FlE/E/FlD=%b expected 11100",
                              {StallF, StallD, FlushE, StallE, FlushD});
        end
        rd_E = 5'd0;
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushE, StallE} !== 4'b0000) begin
            n_err++; $display("FAIL load_use_x0: %b expected 0000", {StallF, StallD, FlushE, StallE});
        end
        rd_E = 5'd7; write_back_E = 2'b00;
        #1;
        n_cmp++;
        if ({StallF, FlushE} !== 2'b00) begin
            n_err++; $display("FAIL load_use_nonload: %b expected 00", {StallF, FlushE});
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        write_back_E = 2'b01; rd_E = 5'd7; rs2_D = 5'd7; mispredict_E = 1'b1; mc_req_E = 1'b1;
        #1;
        n_cmp++;
        if ({FlushD, FlushE, StallF, StallD, StallE, FlushM} !== 6'b110000) begin
            n_err++; $display("FAIL mispredict: FlD/FlE/F/D/E/FlM=%b expected 110000",
                              {FlushD, FlushE, StallF, StallD, StallE, FlushM});
        end
        tick();
        n_cmp++;
        if (mc_start !== 1'b0 || stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL mispredict_no_mc: start=%b cnt=%0d expected 0 0",
                              mc_start, stall_cycles);
        end
        clear_inputs();
    endtask

    task automatic test_multicycle();
        do_reset();
        mc_req_E = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) mc_done = 1'b1;
            #1;
            n_cmp++;
            if ({StallF, StallD, StallE, FlushM} !== {4{c < 5}} || mc_start !== (c == 2)
                || FlushE !== 1'b0) begin
                n_err++; $display("FAIL mc_cycle%0d: stalls=%b start=%b flushE=%b expected %b %b 0",
                                  c, {StallF, StallD, StallE, FlushM}, mc_start, FlushE,
                                  {4{c < 5}}, (c == 2));
            end
            tick();
        end
        mc_req_E = 1'b0; mc_done = 1'b0;
        #1;
        n_cmp++;
        if (stall_cycles !== 32'd4 || StallF !== 1'b0 || mc_start !== 1'b0) begin
            n_err++; $display("FAIL mc_end: cnt=%0d stallF=%b start=%b expected 4 0 0",
                              stall_cycles, StallF, mc_start);
        end
        mc_done = 1'b1;
        #1;
        tick();
        mc_done = 1'b0;
        n_cmp++;
        if (StallF !== 1'b0 || stall_cycles !== 32'd4) begin
            n_err++; $display("FAIL mc_done_idle: stallF=%b cnt=%0d expected 0 4", StallF, stall_cycles);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mc_req_E = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (s_mc_error !== 1'b0 || s_StallF !== 1'b1) begin
            n_err++; $display("FAIL tmo_before: err=%b stallF=%b expected 0 1", s_mc_error, s_StallF);
        end
        tick();
        mc_req_E = 1'b0;
        #1;
        n_cmp++;
        if (s_mc_error !== 1'b1 || s_StallF !== 1'b0 || s_stall_cycles !== 4'd5) begin
            n_err++; $display("FAIL tmo_abort: err=%b stallF=%b cnt=%0d expected 1 0 5",
                              s_mc_error, s_StallF, s_stall_cycles);
        end
        tick();
        n_cmp++;
        if (s_mc_error !== 1'b1 || mc_error !== 1'b0) begin
            n_err++; $display("FAIL tmo_sticky: small=%b big=%b expected 1 0", s_mc_error, mc_error);
        end
        do_reset();
        mc_req_E = 1'b1;
        tick();
        n_cmp++;
        if (s_mc_start !== 1'b1) begin
            n_err++; $display("FAIL tmo_restart: start=%b expected 1", s_mc_start);
        end
        #2;
        rst_n = 1'b0; mc_req_E = 1'b0;
        #1;
        n_cmp++;
        if (s_mc_start !== 1'b0 || s_mc_error !== 1'b0 || s_stall_cycles !== 4'd0
            || mc_start !== 1'b0 || stall_cycles !== 32'd0 || s_StallF !== 1'b0) begin
            n_err++; $display("FAIL async_reset: start=%b err=%b cnt=%0d stallF=%b expected 0 0 0 0",
                              s_mc_start, s_mc_error, s_stall_cycles, s_StallF);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        write_back_E = 2'b01; rd_E = 5'd4; rs1_D = 5'd4;
        repeat (14) tick();
        n_cmp++;
        if (s_stall_cycles !== 4'd14) begin
            n_err++; $display("FAIL sat_14: cnt=%0d expected 14", s_stall_cycles);
        end
        repeat (6) tick();
        n_cmp++;
        if (s_stall_cycles !== 4'd15 || stall_cycles !== 32'd20) begin
            n_err++; $display("FAIL sat_20: small=%0d big=%0d expected 15 20", s_stall_cycles, stall_cycles);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mispredict();
        test_multicycle();
        test_timeout();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
